flt2int_seq: RTL and testbench

Sequencer for the half-precision float-to-integer conversion datapath. It batch-converts a contiguous array of 16-bit floats held in the 8-bit-wide data memory. For each element it reads the big-endian byte pair, hands the operand to the conversion unit with a start/done handshake, and writes the 16-bit result back as a big-endian pair. It sits between the top-level start/done interface and the shared data_mem port.

---
 rtl/flt2int_seq.sv | 193 +++++++++++++++++++
 tb/tb_flt2int_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flt2int_seq.sv
// flt2int_seq: walks an array of big-endian half-precision floats in the
// byte-wide data memory. Each element goes through the external converter,
// and the 16-bit result is written back big-endian.
// Optional build macro FLT2INT_SEQ_STATS_EN adds sat_cnt_o, which counts
// operands with exponent >= 30.
//
// state | meaning
// IDLE  | waiting for start after reset
// RD_HI | read the float high byte at src
// RD_LO | read the float low byte at src+1
// CVT   | one-cycle converter launch pulse
// WAIT  | wait for converter done, bounded by TIMEOUT
// WR_HI | write the result high byte at dst
// WR_LO | write the result low byte at dst+1, then advance or finish
// DONE  | batch finished or aborted, done_o held until the next start
module flt2int_seq #(
  parameter logic [7:0] SRC_BASE = 8'd64,
  parameter logic [7:0] DST_BASE = 8'd66,
  parameter int         TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [7:0]  count_i,
  input  logic [7:0]  src_i,
  input  logic [7:0]  dst_i,
  output logic [7:0]  mem_addr_o,
  output logic        mem_we_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  output logic [15:0] cvt_flt_o,
  output logic        cvt_start_o,
  input  logic        cvt_done_i,
  input  logic [15:0] cvt_int_i,
`ifdef FLT2INT_SEQ_STATS_EN
  output logic [7:0]  sat_cnt_o,
`endif
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  // The timeout counter holds TIMEOUT-1 down to 0, so it needs clog2(TIMEOUT) bits.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_HI, RD_LO, CVT, WAIT, WR_HI, WR_LO, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
  logic [15:0]   flt_q, flt_d, res_q, res_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [7:0]    sat_q, sat_d;
  logic [7:0]    addr_q, addr_d, wdata_q, wdata_d;
  logic          we_q, we_d, cst_q, cst_d, busy_q, busy_d, done_q, done_d;

  // Next-state logic. Outputs are decoded from the next state so that they
  // are registered and line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    flt_d   = flt_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          cnt_d   = count_i;
          src_d   = src_i;
          dst_d   = dst_i;
          err_d   = 1'b0;
          sat_d   = 8'd0;
          state_d = (count_i == 8'd0) ? DONE : RD_HI;
        end
      end
      RD_HI: begin
        flt_d[15:8] = mem_rdata_i;
        state_d     = RD_LO;
      end
      RD_LO: begin
        flt_d[7:0] = mem_rdata_i;
        state_d    = CVT;
      end
      CVT: begin
        tmo_d   = TMO_LOAD;
        state_d = WAIT;
        if (flt_q[14:10] >= 5'd30 && sat_q != 8'hFF) begin
          sat_d = sat_q + 8'd1;
        end
      end
      WAIT: begin
        if (cvt_done_i) begin
          res_d   = cvt_int_i;
          state_d = WR_HI;
        end else if (tmo_q == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      WR_HI: state_d = WR_LO;
      WR_LO: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_d == 8'd0) begin
          state_d = DONE;
        end else begin
          src_d   = src_q + 8'd2;
          dst_d   = dst_q + 8'd2;
          state_d = RD_HI;
        end
      end
      default: state_d = IDLE;
    endcase

    addr_d  = 8'd0;
    wdata_d = 8'd0;
    case (state_d)
      RD_HI: addr_d = src_d;
      RD_LO: addr_d = src_d + 8'd1;
      WR_HI: begin
        addr_d  = dst_d;
        wdata_d = res_d[15:8];
      end
      WR_LO: begin
        addr_d  = dst_d + 8'd1;
        wdata_d = res_d[7:0];
      end
      default: ;
    endcase
    we_d   = (state_d == WR_HI) || (state_d == WR_LO);
    cst_d  = (state_d == CVT);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // State, datapath and registered outputs. Reset aborts any batch at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      src_q   <= SRC_BASE;
      dst_q   <= DST_BASE;
      cnt_q   <= 8'd0;
      flt_q   <= 16'd0;
      res_q   <= 16'd0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      sat_q   <= 8'd0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      we_q    <= 1'b0;
      cst_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cst_q   <= cst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign cvt_flt_o   = flt_q;
  assign cvt_start_o = cst_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
`ifdef FLT2INT_SEQ_STATS_EN
  assign sat_cnt_o   = sat_q;
`endif

endmodule

// File: tb/tb_flt2int_seq.sv
// Bench for flt2int_seq: a byte memory model, a converter model with
// programmable latency, and a scoreboard of expected writes and operands.
module tb_flt2int_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  count_v = 8'd0, src_v = 8'd0, dst_v = 8'd0;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] cvt_flt, cvt_int = 16'd0;
  logic        cvt_start, cvt_done = 1'b0;
  logic        busy, done, err;
`ifdef FLT2INT_SEQ_STATS_EN
  logic [7:0]  sat_cnt;
`endif

  flt2int_seq dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .count_i(count_v), .src_i(src_v), .dst_i(dst_v),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .cvt_flt_o(cvt_flt), .cvt_start_o(cvt_start),
    .cvt_done_i(cvt_done), .cvt_int_i(cvt_int),
`ifdef FLT2INT_SEQ_STATS_EN
    .sat_cnt_o(sat_cnt),
`endif
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  // Memory model: combinational read, posedge write, plus a bench poke port.
  logic [7:0] mem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_a = 8'd0, pl_d = 8'd0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Converter model: hand-picked results for the operands the tests use.
  function automatic logic [15:0] cvt_model(input logic [15:0] f);
    case (f)
      16'h3C00: return 16'h0001;
      16'h4000: return 16'h0002;
      16'h4200: return 16'h0003;
      16'h4400: return 16'h0004;
      16'h7C00: return 16'h7FFF;
      default:  return 16'hDEAD;
    endcase
  endfunction

  logic cvt_en = 1'b1;
  int   cvt_lat = 1;
  int   cvt_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cvt_cnt  = 0;
      cvt_done = 1'b0;
    end else if (cvt_start) begin
      cvt_cnt  = cvt_en ? cvt_lat : 0;
      cvt_done = 1'b0;
    end else if (cvt_cnt > 0) begin
      cvt_cnt  = cvt_cnt - 1;
      cvt_done = (cvt_cnt == 0);
      cvt_int  = cvt_model(cvt_flt);
    end else begin
      cvt_done = 1'b0;
    end
  end

  // Scoreboard
  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t         wq[$];
  logic [15:0] oq[$];
  int total = 0, fails = 0, passed = 0;
  int n_wr = 0, n_st = 0;
  logic prev_st = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected writes and converter operands as the DUT presents them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st = 1'b0;
    end else begin
      if (mem_we) begin
        n_wr++;
        if (wq.size() == 0) begin
          chk("unexpected_write", {mem_addr, mem_wdata}, 16'h0);
        end else begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
        end
      end
      if (cvt_start) begin
        n_st++;
        chk("start_single_cycle", prev_st, 1'b0);
        if (oq.size() == 0) chk("unexpected_start", cvt_flt, 16'h0);
        else chk("cvt_operand", cvt_flt, oq.pop_front());
      end
      prev_st = cvt_start;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_a = a; pl_d = d; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic poke16(input logic [7:0] a, input logic [15:0] v);
    poke(a, v[15:8]);
    poke(a + 8'd1, v[7:0]);
  endtask

  task automatic expect_elem(input logic [7:0] dst, input logic [15:0] op);
    logic [15:0] r;
    r = cvt_model(op);
    oq.push_back(op);
    wq.push_back('{a: dst, d: r[15:8]});
    wq.push_back('{a: dst + 8'd1, d: r[7:0]});
  endtask

  // Start is sampled at the posedge inside this task.
  task automatic do_start(input logic [7:0] c, input logic [7:0] s, input logic [7:0] d);
    @(negedge clk);
    count_v = c; src_v = s; dst_v = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts posedges after the start-sample edge until done_o rises.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int cyc, st0, wr0, k;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {mem_addr, mem_we, mem_wdata, cvt_start, busy, done, err}, 0);
    chk("rst_flt", cvt_flt, 16'h0);
    for (int i = 0; i < 256; i++) poke(i[7:0], 8'hEE);
    @(negedge clk);
    rst_n = 1'b1;

    // Single element, 1.0 -> 1, converter latency 1: 6 edges to done.
    poke16(8'd64, 16'h3C00);
    cvt_lat = 1;
    expect_elem(8'd66, 16'h3C00);
    do_start(8'd1, 8'd64, 8'd66);
    chk("single_busy_after_start", {busy, done}, 2'b10);
    wait_done(cyc);
    chk("single_cycles", cyc, 6);
    chk("single_busy_low", busy, 1'b0);
    chk("single_mem66", mem[66], 8'h00);
    chk("single_mem67", mem[67], 8'h01);
    chk("single_wq_empty", wq.size(), 0);

    // Batch of 3, latency 3: 8 cycles per element.
    poke16(8'h40, 16'h4000);
    poke16(8'h42, 16'h4200);
    poke16(8'h44, 16'h4400);
    cvt_lat = 3;
    expect_elem(8'h80, 16'h4000);
    expect_elem(8'h82, 16'h4200);
    expect_elem(8'h84, 16'h4400);
    st0 = n_st;
    do_start(8'd3, 8'h40, 8'h80);
    wait_done(cyc);
    chk("batch_cycles", cyc, 24);
    chk("batch_starts", n_st - st0, 3);
    chk("batch_mem85", mem[8'h85], 8'h04);
    chk("batch_wq_empty", wq.size(), 0);

    // Converter never answers: abort after 16 WAIT cycles, nothing written.
    cvt_en = 1'b0;
    oq.push_back(16'h4000);
    wr0 = n_wr;
    do_start(8'd2, 8'h40, 8'h90);
    wait_done(cyc);
    chk("timeout_cycles", cyc, 19);
    chk("timeout_err", {err, done, busy}, 3'b110);
    chk("timeout_no_write", n_wr - wr0, 0);
    chk("timeout_mem90", mem[8'h90], 8'hEE);
    repeat (3) @(posedge clk);
    #1 chk("timeout_err_sticky", err, 1'b1);
    cvt_en = 1'b1;

    // count=0: DONE straight away, err cleared, no activity.
    st0 = n_st;
    wr0 = n_wr;
    do_start(8'd0, 8'h40, 8'h90);
    chk("zero_state", {err, done, busy}, 3'b010);
    repeat (4) @(posedge clk);
    #1;
    chk("zero_no_start", n_st - st0, 0);
    chk("zero_no_write", n_wr - wr0, 0);

    // Reset while element 2 of 4 is in WAIT.
    poke16(8'h10, 16'h3C00);
    poke16(8'h12, 16'h4000);
    poke16(8'h14, 16'h4200);
    poke16(8'h16, 16'h4400);
    cvt_lat = 5;
    expect_elem(8'h20, 16'h3C00);
    oq.push_back(16'h4000);
    st0 = n_st;
    do_start(8'd4, 8'h10, 8'h20);
    k = 0;
    while (n_st - st0 < 2 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("reset_reach_elem2", (n_st - st0 >= 2), 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {mem_addr, mem_we, mem_wdata, cvt_start, busy, done, err}, 0);
    chk("midrst_flt", cvt_flt, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_mem20_21", {mem[8'h20], mem[8'h21]}, 16'h0001);
    chk("midrst_mem22_27", {mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25], mem[8'h26], mem[8'h27]}, {6{8'hEE}});
    chk("midrst_queues", wq.size() + oq.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cvt_lat = 1;
    expect_elem(8'h40, 16'h4400);
    do_start(8'd1, 8'h16, 8'h40);
    wait_done(cyc);
    chk("postrst_cycles", cyc, 6);
    chk("postrst_mem41", mem[8'h41], 8'h04);

    // Address wrap: reads 0xFE,0xFF,0x00,0x01.
    poke16(8'hFE, 16'h7C00);
    poke16(8'h00, 16'h4000);
    expect_elem(8'h30, 16'h7C00);
    expect_elem(8'h32, 16'h4000);
    do_start(8'd2, 8'hFE, 8'h30);
    wait_done(cyc);
    chk("wrap_cycles", cyc, 12);
    chk("wrap_mem30_33", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'h7FFF0002);
    chk("wrap_queues", wq.size() + oq.size(), 0);
`ifdef FLT2INT_SEQ_STATS_EN
    chk("wrap_sat_cnt", sat_cnt, 8'd1);
`endif

    repeat (2) @(posedge clk);
    passed = total - fails;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
